// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue: in-order queue between the tournament predictor's
// prediction port and branch resolution. Each prediction's PC and metadata
// are stored at fetch; on resolve the head is popped and a registered
// bht_update_t is sent back to the predictor.

// Minimal core-configuration package so the queue elaborates stand-alone.
package config_pkg;
  typedef struct packed {
    int unsigned VLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd32};
endpackage

module bp_resolve_queue #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter type bht_update_t  = logic,
  parameter type bp_metadata_t = logic,
  parameter int unsigned DEPTH = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic                                  debug_mode_i,
  input  logic                                  push_valid_i,
  input  logic [CVA6Cfg.VLEN-1:0]               push_pc_i,
  input  logic [$bits(bp_metadata_t)-1:0]       push_metadata_i,
  output logic                                  ready_o,
  input  logic                                  resolve_valid_i,
  input  logic [CVA6Cfg.VLEN-1:0]               resolve_pc_i,
  input  logic                                  resolve_taken_i,
  output bht_update_t                           bht_update_o,
  output logic [$clog2(DEPTH):0]                count_o,
  output logic                                  overflow_o,
  output logic                                  underflow_o,
  output logic                                  pc_mismatch_o
);

  localparam int unsigned VLEN    = CVA6Cfg.VLEN;
  localparam int unsigned MW      = $bits(bp_metadata_t);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = VLEN + MW;
  // Update layout matches the predictor's struct: {valid, pc, taken, metadata}.
  localparam int unsigned UPD_W   = 1 + VLEN + 1 + MW;

  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [UPD_W-1:0] upd_q, upd_d;
  logic             overflow_q, underflow_q, pc_mismatch_q;

  logic             full;
  logic             push_acc;
  logic             pop;
  logic [ENTRY_W-1:0] head;
  logic [VLEN-1:0]  head_pc;
  logic [MW-1:0]    head_meta;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign push_acc  = push_valid_i && !full && !flush_i;
  // Gating on the registered count keeps a same-cycle push invisible to the pop.
  assign pop       = resolve_valid_i && (count_q != '0);
  assign head      = mem[rd_ptr_q];
  assign head_pc   = head[ENTRY_W-1 -: VLEN];
  assign head_meta = head[MW-1:0];

  // Next occupancy: flush wins after the same-cycle pop has been accounted for.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      unique case ({push_acc, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Update built from the head entry; debug mode pops but never signals valid.
  always_comb begin
    upd_d = '0;
    if (pop) begin
      upd_d = {!debug_mode_i, head_pc, resolve_taken_i, head_meta};
    end
  end

  // Entry storage write port.
  // NOTE: the storage array has no reset; occupancy is tracked by count_q and
  // the pointers, so stale contents are never observable.
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      mem[wr_ptr_q] <= {push_pc_i, push_metadata_i};
    end
  end

  // Pointers, occupancy, registered update and status pulses.
  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      upd_q         <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      pc_mismatch_q <= 1'b0;
    end else begin
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)      rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q       <= count_d;
      upd_q         <= upd_d;
      overflow_q    <= push_valid_i && full;
      underflow_q   <= resolve_valid_i && (count_q == '0);
      pc_mismatch_q <= pop && (resolve_pc_i != head_pc);
    end
  end

  assign ready_o       = !full;
  assign count_o       = count_q;
  assign bht_update_o  = bht_update_t'(upd_q);
  assign overflow_o    = overflow_q;
  assign underflow_o   = underflow_q;
  assign pc_mismatch_o = pc_mismatch_q;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue: basic flow, fill/wrap, flush,
// empty/mismatch, debug mode and asynchronous reset mid-operation.
module tb_bp_resolve_queue;

  localparam config_pkg::cva6_cfg_t CFG = '{VLEN: 32'd32};
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [3:0] gidx;
    logic [3:0] lidx;
    logic       g_taken;
    logic       l_taken;
  } meta_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
    meta_t       metadata;
  } upd_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        debug_mode_i = 1'b0;
  logic        push_valid_i = 1'b0;
  logic [31:0] push_pc_i = '0;
  logic [9:0]  push_metadata_i = '0;
  logic        ready_o;
  logic        resolve_valid_i = 1'b0;
  logic [31:0] resolve_pc_i = '0;
  logic        resolve_taken_i = 1'b0;
  upd_t        bht_update_o;
  logic [3:0]  count_o;
  logic        overflow_o, underflow_o, pc_mismatch_o;

  int vectors = 0;
  int miscompares = 0;

  bp_resolve_queue #(
    .CVA6Cfg(CFG),
    .bht_update_t(upd_t),
    .bp_metadata_t(meta_t),
    .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .flush_i(flush_i),
    .debug_mode_i(debug_mode_i),
    .push_valid_i(push_valid_i),
    .push_pc_i(push_pc_i),
    .push_metadata_i(push_metadata_i),
    .ready_o(ready_o),
    .resolve_valid_i(resolve_valid_i),
    .resolve_pc_i(resolve_pc_i),
    .resolve_taken_i(resolve_taken_i),
    .bht_update_o(bht_update_o),
    .count_o(count_o),
    .overflow_o(overflow_o),
    .underflow_o(underflow_o),
    .pc_mismatch_o(pc_mismatch_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic upd_t mk(input logic v, input logic [31:0] pc, input logic t, input logic [9:0] m);
    upd_t u;
    u.valid    = v;
    u.pc       = pc;
    u.taken    = t;
    u.metadata = meta_t'(m);
    return u;
  endfunction

  // One clock edge, then sample 1ns later and drop all strobes.
  task automatic tick();
    @(posedge clk_i);
    #1;
    push_valid_i    = 1'b0;
    resolve_valid_i = 1'b0;
    flush_i         = 1'b0;
  endtask

  task automatic do_push(input logic [31:0] pc, input logic [9:0] m);
    push_valid_i    = 1'b1;
    push_pc_i       = pc;
    push_metadata_i = m;
  endtask

  task automatic do_resolve(input logic [31:0] pc, input logic t);
    resolve_valid_i = 1'b1;
    resolve_pc_i    = pc;
    resolve_taken_i = t;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_upd", 64'(bht_update_o), 64'd0);
    check("rst_flags", 64'({overflow_o, underflow_o, pc_mismatch_o}), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Basic flow
    do_push(32'h1000, 10'h0A5); tick();
    check("basic_cnt1", 64'(count_o), 64'd1);
    do_push(32'h1004, 10'h15A); tick();
    check("basic_cnt2", 64'(count_o), 64'd2);
    do_resolve(32'h1000, 1'b1); tick();
    check("basic_upd0", 64'(bht_update_o), 64'(mk(1'b1, 32'h1000, 1'b1, 10'h0A5)));
    check("basic_mm0", 64'(pc_mismatch_o), 64'd0);
    do_resolve(32'h1004, 1'b0); tick();
    check("basic_upd1", 64'(bht_update_o), 64'(mk(1'b1, 32'h1004, 1'b0, 10'h15A)));
    check("basic_cnt0", 64'(count_o), 64'd0);
    tick();
    check("basic_idle", 64'(bht_update_o.valid), 64'd0);

    // Fill and wrap
    for (int i = 0; i < 8; i++) begin
      do_push(32'h3000 + 32'(4 * i), 10'(i)); tick();
    end
    check("fill_cnt", 64'(count_o), 64'd8);
    check("fill_ready", 64'(ready_o), 64'd0);
    do_push(32'h3100, 10'h3FF); tick();
    check("ovf_pulse", 64'(overflow_o), 64'd1);
    check("ovf_cnt", 64'(count_o), 64'd8);
    tick();
    check("ovf_clear", 64'(overflow_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      do_resolve(32'h3000 + 32'(4 * i), 1'b1); tick();
      check("pop3_upd", 64'(bht_update_o), 64'(mk(1'b1, 32'h3000 + 32'(4 * i), 1'b1, 10'(i))));
    end
    check("pop3_cnt", 64'(count_o), 64'd5);
    for (int i = 8; i < 11; i++) begin
      do_push(32'h3000 + 32'(4 * i), 10'(i)); tick();
    end
    check("wrap_cnt", 64'(count_o), 64'd8);
    for (int k = 3; k < 11; k++) begin
      if (k == 3) do_push(32'h3FFC, 10'h3FF);
      do_resolve(32'h3000 + 32'(4 * k), 1'(k)); tick();
      check("wrap_upd", 64'(bht_update_o), 64'(mk(1'b1, 32'h3000 + 32'(4 * k), 1'(k), 10'(k))));
      if (k == 3) begin
        check("full_pushpop_ovf", 64'(overflow_o), 64'd1);
        check("full_pushpop_cnt", 64'(count_o), 64'd7);
      end
    end
    check("wrap_empty", 64'(count_o), 64'd0);

    // Flush with same-cycle resolve and push
    for (int i = 0; i < 5; i++) begin
      do_push(32'h4000 + 32'(4 * i), 10'h20 + 10'(i)); tick();
    end
    check("fl_cnt5", 64'(count_o), 64'd5);
    flush_i = 1'b1;
    do_resolve(32'h4000, 1'b1);
    do_push(32'h4100, 10'h3C3);
    tick();
    check("fl_upd", 64'(bht_update_o), 64'(mk(1'b1, 32'h4000, 1'b1, 10'h20)));
    check("fl_cnt0", 64'(count_o), 64'd0);
    check("fl_ready", 64'(ready_o), 64'd1);
    do_push(32'h5000, 10'h055); tick();
    do_resolve(32'h5000, 1'b0); tick();
    check("fl_after", 64'(bht_update_o), 64'(mk(1'b1, 32'h5000, 1'b0, 10'h055)));

    // Empty and mismatch
    do_resolve(32'h6000, 1'b1); tick();
    check("uf_pulse", 64'(underflow_o), 64'd1);
    check("uf_upd", 64'(bht_update_o), 64'd0);
    tick();
    check("uf_clear", 64'(underflow_o), 64'd0);
    do_push(32'h2000, 10'h077); tick();
    do_resolve(32'h2008, 1'b0); tick();
    check("mm_pulse", 64'(pc_mismatch_o), 64'd1);
    check("mm_upd", 64'(bht_update_o), 64'(mk(1'b1, 32'h2000, 1'b0, 10'h077)));
    check("mm_cnt", 64'(count_o), 64'd0);
    tick();
    check("mm_clear", 64'(pc_mismatch_o), 64'd0);

    // Push and resolve together, empty then non-empty
    do_push(32'h7000, 10'h011); do_resolve(32'h7000, 1'b1); tick();
    check("pr_empty_uf", 64'(underflow_o), 64'd1);
    check("pr_empty_cnt", 64'(count_o), 64'd1);
    check("pr_empty_upd", 64'(bht_update_o.valid), 64'd0);
    do_push(32'h7004, 10'h012); do_resolve(32'h7000, 1'b1); tick();
    check("pr_upd", 64'(bht_update_o), 64'(mk(1'b1, 32'h7000, 1'b1, 10'h011)));
    check("pr_cnt", 64'(count_o), 64'd1);
    do_resolve(32'h7004, 1'b0); tick();
    check("pr_upd2", 64'(bht_update_o), 64'(mk(1'b1, 32'h7004, 1'b0, 10'h012)));

    // Debug mode
    debug_mode_i = 1'b1;
    do_push(32'h8000, 10'h081); tick();
    do_push(32'h8004, 10'h082); tick();
    check("dbg_cnt2", 64'(count_o), 64'd2);
    do_resolve(32'h8000, 1'b1); tick();
    check("dbg_v0", 64'(bht_update_o.valid), 64'd0);
    check("dbg_cnt1", 64'(count_o), 64'd1);
    do_resolve(32'h8004, 1'b1); tick();
    check("dbg_v1", 64'(bht_update_o.valid), 64'd0);
    check("dbg_cnt0", 64'(count_o), 64'd0);
    debug_mode_i = 1'b0;

    // Asynchronous reset mid-operation
    do_push(32'h9000, 10'h091); tick();
    do_push(32'h9004, 10'h092); tick();
    do_resolve(32'h9000, 1'b1); tick();
    check("ar_pre_upd", 64'(bht_update_o.valid), 64'd1);
    do_resolve(32'h9004, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("ar_cnt", 64'(count_o), 64'd0);
    check("ar_upd", 64'(bht_update_o), 64'd0);
    check("ar_ready", 64'(ready_o), 64'd1);
    resolve_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    check("ar_noupd", 64'(bht_update_o.valid), 64'd0);
    check("ar_cnt_after", 64'(count_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bp_resolve_queue.md
# bp_resolve_queue

In-order queue sitting between the tournament predictor's prediction port and the branch-resolution logic. At fetch it captures each prediction's PC and `bp_metadata_t` (global/local indices plus component outcomes). When the branch resolves, it pops the head entry and drives a registered `bht_update_t` back into the predictor's `bht_update_i`. This closes the predict→update loop that the predictor bench currently drives by hand.

## Interface
Parameters:
- `CVA6Cfg`, default `config_pkg::cva6_cfg_empty`: core configuration; `VLEN` sets the PC width.
- `bht_update_t`, default `logic`: update struct `{valid, pc[VLEN], taken, metadata}`, identical to the predictor's.
- `bp_metadata_t`, default `logic`: metadata struct, identical to the predictor's.
- `DEPTH`, default 8: number of entries; power of two, ≥2.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `flush_i`, in, 1: discard all queued entries.
- `debug_mode_i`, in, 1: suppress predictor updates.
- `push_valid_i`, in, 1: a prediction was consumed at fetch.
- `push_pc_i`, in, VLEN: PC of the predicted branch.
- `push_metadata_i`, in, `$bits(bp_metadata_t)`: metadata from `bht_prediction_o`.
- `ready_o`, out, 1: queue not full.
- `resolve_valid_i`, in, 1: the oldest outstanding branch resolved.
- `resolve_pc_i`, in, VLEN: PC of the resolved branch.
- `resolve_taken_i`, in, 1: actual outcome.
- `bht_update_o`, out, `bht_update_t`: to the predictor's `bht_update_i`.
- `count_o`, out, `$clog2(DEPTH)+1`: occupancy.
- `overflow_o`, out, 1: one-cycle pulse, push dropped.
- `underflow_o`, out, 1: one-cycle pulse, resolve on an empty queue.
- `pc_mismatch_o`, out, 1: one-cycle pulse, `resolve_pc_i` ≠ head PC.

## Operation
- Storage is a circular buffer of `{pc, metadata}`.
- Pointers are `wr_ptr` and `rd_ptr`, each `$clog2(DEPTH)` bits and wrapping modulo DEPTH. `count` is a separate counter.
- `ready_o = (count != DEPTH)`, combinational from registered state.
- **Push** is accepted when `push_valid_i && ready_o && !flush_i`. The entry is written at `wr_ptr` and `wr_ptr` increments.
- **Push when full** is dropped and `overflow_o` pulses, even if a resolve happens in the same cycle.
- **Resolve** with `count != 0` pops the head and increments `rd_ptr`. Next cycle, `bht_update_o` carries:
  - `pc` = head PC, `metadata` = head metadata, `taken = resolve_taken_i`;
  - `valid = !debug_mode_i`.
- **PC check:** on a pop where `resolve_pc_i` ≠ head PC, `pc_mismatch_o` pulses. The update is still emitted, using the stored PC.
- **Resolve when empty:** no pop, `bht_update_o.valid = 0`, `underflow_o` pulses.
- **Push and resolve together:** both take effect and `count` is unchanged. When `count == 0` the push is written but is not visible to the same-cycle resolve, which underflows.
- **Flush:** any same-cycle resolve is processed first and its update is still emitted. Then both pointers and `count` go to 0, and any same-cycle push is discarded.
- **Debug mode:** entries still pop, so the queue stays aligned; no update is signalled.

## Timing
- Reset, asynchronous: pointers, `count`, `bht_update_o` (all fields), `overflow_o`, `underflow_o` and `pc_mismatch_o` all become 0. `ready_o` becomes 1.
- Update latency: resolve in cycle N → `bht_update_o.valid` in cycle N+1 for exactly one cycle.
- `overflow_o`, `underflow_o` and `pc_mismatch_o` are registered and appear in cycle N+1.
- Push-to-resolvable latency is 1 cycle: an entry pushed in cycle N can be popped in cycle N+1.
- `count_o` and `ready_o` reflect registered state at the start of each cycle.
- Reset asserted mid-operation empties the queue immediately. No update is emitted for pending entries.

## Test plan
- **Basic flow:** push PC 0x1000 and PC 0x1004 with distinct metadata, then resolve taken=1 and then taken=0 → two updates in consecutive cycles. Each has the matching PC and metadata, `valid=1`, and `count_o` ends at 0.
- **Fill and wrap:** push 8 entries (`count_o=8`, `ready_o=0`). A 9th push gives `overflow_o=1` and no state change. Pop 3, push 3 more → pointers wrap, and the following 8 pops emit PCs in strict FIFO order.
- **Flush:** with 5 entries queued, assert `flush_i` together with a resolve and a push → one update for the head is emitted, the push is dropped, and `count_o=0` next cycle.
- **Empty and mismatch:** resolve on an empty queue → `underflow_o=1`, `bht_update_o.valid=0`. Push 0x2000 then resolve with PC 0x2008 → `pc_mismatch_o=1` and an update with `pc=0x2000`.
- **Debug mode:** with `debug_mode_i=1`, 2 entries then 2 resolves → `bht_update_o.valid` stays 0 and `count_o` goes from 2 to 0.
- **Closed loop:** connect to the tournament predictor and run 10000 random predict/resolve cycles → predictor memories match the shadow model.
